// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and constants for the UART TX scheduler.
package uart_tx_sched_pkg;

    localparam int UART_BW         = 8;
    localparam int TIMEOUT_CYC_DEF = 2000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    int               pos;
    int               sum;

    // Rotate so bit 0 is the request at ptr; the lowest set bit is then the winner.
    assign rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        pos = 0;
        for (int i = N_REQ - 1; i >= 0; i--)
            pos = rot[i] ? i : pos;
        sum = int'(ptr) + pos;
        idx = 3'(sum >= N_REQ ? sum - N_REQ : sum);
    end

    assign any   = |req;
    assign grant = any ? N_REQ'(1) << idx : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-locking scheduler sharing one UART transmitter.
// Optional per-phase timeout enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [UART_BW*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [UART_BW-1:0]       tx_data,
    output logic                     tx_en,
    input  logic                     tx_busy,
    output logic                     byte_done,
    output logic [2:0]               grant_id,
    output logic                     sched_busy,
    output logic                     timeout_err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_tx_sched: unsupported N_REQ or TIMEOUT_CYC");
    end

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [2:0]         lock_owner;
    logic [2:0]         g;
    logic               lock_held;
    logic               any;
    logic               take;
    logic               abort;
    logic               sel_last;
    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   grant;
    logic [UART_BW-1:0] sel_data;

    // A held lock narrows the candidates to the owner, even if it has nothing pending.
    assign cand = req_valid & (lock_held ? N_REQ'(1) << lock_owner : '1);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g),
        .any   (any)
    );

    assign take       = reset && state == S_IDLE && !tx_busy && any;
    assign req_ready  = take ? grant : '0;
    assign sched_busy = state != S_IDLE || lock_held;
    assign sel_last   = |(req_last & grant);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++)
            sel_data |= {UART_BW{grant[i]}} & req_data[i*UART_BW +: UART_BW];
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] phase_cnt;

    // Abort only when the phase would otherwise keep waiting, so a normal exit wins a tie.
    assign abort = phase_cnt == TW'(TIMEOUT_CYC - 1) &&
                   ((state == S_START && !tx_busy) || (state == S_SEND && tx_busy));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            phase_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            phase_cnt   <= (state == S_IDLE || (state == S_START && tx_busy) || abort) ? '0 : phase_cnt + 1'b1;
            timeout_err <= timeout_err | abort;
        end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            lock_owner <= '0;
            lock_held  <= 1'b0;
            tx_data    <= '0;
            tx_en      <= 1'b0;
            grant_id   <= '0;
            byte_done  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                S_IDLE:
                    if (take) begin
                        tx_data    <= sel_data;
                        tx_en      <= 1'b1;
                        grant_id   <= g;
                        rr_ptr     <= (int'(g) == N_REQ - 1) ? 3'd0 : g + 3'd1;
                        lock_held  <= ~sel_last;
                        lock_owner <= g;
                        state      <= S_START;
                    end
                S_START:
                    if (tx_busy) begin
                        tx_en <= 1'b0;
                        state <= S_SEND;
                    end else if (abort) begin
                        tx_en     <= 1'b0;
                        lock_held <= 1'b0;
                        state     <= S_IDLE;
                    end
                S_SEND:
                    if (!tx_busy) begin
                        byte_done <= 1'b1;
                        state     <= S_IDLE;
                    end else if (abort) begin
                        lock_held <= 1'b0;
                        state     <= S_IDLE;
                    end
                default:
                    state <= S_IDLE;
            endcase
        end

endmodule
